adder32_seq2: RTL and testbench

//  Sequential 32-bit adder built around one WIDTH/2-bit add per cycle: low half first, then high half plus registered carry.

---
 rtl/adder32_seq2.sv | 138 +++++++++++++
 tb/tb_adder32_seq2.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/adder32_seq2.sv
// adder32_seq2
//   Sequential WIDTH-bit adder that performs one WIDTH/2-bit add per cycle:
//   the low half first, then the high half plus the carry registered from
//   the low half. It stages operands and holds the result, with valid/ready
//   on both sides so that either neighbour can stall it.
//
// Ports
//   clk        rising-edge clock for all state
//   reset_n    synchronous active-low reset
//   in_valid   operands are present on input1/input2
//   in_ready   block can accept operands this cycle
//   input1     operand A
//   input2     operand B
//   out_valid  out/carry_out/overflow hold a valid result
//   out_ready  downstream takes the result this cycle
//   out        A+B mod 2^WIDTH
//   carry_out  unsigned carry out of bit WIDTH-1
//   overflow   signed overflow of A+B
//
// WIDTH must be even.

module adder32_seq2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);

  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [HALF-1:0]  lo;
  logic             c;
  logic             accept;
  logic [HALF:0]    sum_lo;
  logic [HALF:0]    sum_hi;

  assign accept = in_valid && in_ready;

  // Each half is an unsigned HALF+1-bit add; the top bit is the carry.
  assign sum_lo = {1'b0, opa[HALF-1:0]} + {1'b0, opb[HALF-1:0]};
  assign sum_hi = {1'b0, opa[WIDTH-1:HALF]} + {1'b0, opb[WIDTH-1:HALF]}
                + {{HALF{1'b0}}, c};

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. In DONE a new operation may only start on the same
  // edge the current result is taken downstream.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = LO;
      LO:   state_next = HI;
      HI:   state_next = DONE;
      DONE: begin
        if (out_ready) begin
          state_next = in_valid ? LO : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs depend only on state and out_ready, so there is no
  // combinational path from the operands to any output.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath. The low-half carry is rewritten in LO for every operation, so
  // the high half only ever sees the carry of its own operands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      opa       <= '0;
      opb       <= '0;
      lo        <= '0;
      c         <= 1'b0;
      out       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        opa <= input1;
        opb <= input2;
      end
      if (state == LO) begin
        lo <= sum_lo[HALF-1:0];
        c  <= sum_lo[HALF];
      end
      if (state == HI) begin
        out       <= {sum_hi[HALF-1:0], lo};
        carry_out <= sum_hi[HALF];
        overflow  <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                     (sum_hi[HALF-1] != opa[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_adder32_seq2.sv
// tb_adder32_seq2
//   Directed bench for adder32_seq2 with hand-computed expected results.
//   Inputs change on the falling edge and outputs are sampled there too,
//   half a period away from the active rising edge.

module tb_adder32_seq2;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] input1;
  logic [31:0] input2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        carry_out;
  logic        overflow;

  int compared;
  int mismatched;

  adder32_seq2 #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input1    (input1),
    .input2    (input2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one full clock and stop at the following falling edge.
  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait (bounded) until out_valid is high at a falling edge.
  task automatic waitResult(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_result_arrives"}, 64'(seen), 64'd1);
  endtask

  // Run one operation from IDLE with out_ready held high and check the result.
  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_out,
                               input logic exp_co, input logic exp_ov);
    in_valid  = 1'b1;
    input1    = a;
    input2    = b;
    out_ready = 1'b0;
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    nextCycle();
    in_valid = 1'b0;
    input1   = 32'hDEAD_BEEF;
    input2   = 32'hCAFE_F00D;
    checkOutput({tag, "_busy_no_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
    waitResult(tag);
    checkOutput({tag, "_out"}, 64'(out), 64'(exp_out));
    checkOutput({tag, "_carry_out"}, 64'(carry_out), 64'(exp_co));
    checkOutput({tag, "_overflow"}, 64'(overflow), 64'(exp_ov));
    out_ready = 1'b1;
    nextCycle();
    out_ready = 1'b0;
    checkOutput({tag, "_released"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    input1     = 32'h1111_1111;
    input2     = 32'h2222_2222;

    // Reset held three edges with in_valid asserted.
    @(negedge clk);
    for (int i = 0; i < 3; i++) nextCycle();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out", 64'(out), 64'd0);
    checkOutput("reset_carry_out", 64'(carry_out), 64'd0);
    checkOutput("reset_overflow", 64'(overflow), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    nextCycle();
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
    checkOutput("idle_out_valid", 64'(out_valid), 64'd0);

    // Directed vectors.
    applyStimulus("no_carry", 32'h0001_0001, 32'h0001_0001, 32'h0002_0002, 1'b0, 1'b0);
    applyStimulus("half_carry", 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0);
    applyStimulus("hi_wrap", 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus("full_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    applyStimulus("neg_ovf", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
    applyStimulus("mixed", 32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0, 1'b0);

    // Backpressure: result held while new operands wait.
    in_valid = 1'b1;
    input1   = 32'h0000_0001;
    input2   = 32'h0000_0002;
    nextCycle();
    in_valid = 1'b0;
    waitResult("bp_first");
    in_valid = 1'b1;
    input1   = 32'h0000_0010;
    input2   = 32'h0000_0020;
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_out", 64'(out), 64'h3);
      checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_in_ready_follows", 64'(in_ready), 64'd1);
    nextCycle();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    input1    = 32'hFFFF_FFFF;
    input2    = 32'hFFFF_FFFF;
    checkOutput("bp_handoff_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_handoff_busy", 64'(in_ready), 64'd0);
    waitResult("bp_second");
    checkOutput("bp_second_out", 64'(out), 64'h30);
    checkOutput("bp_second_co", 64'(carry_out), 64'd0);
    out_ready = 1'b1;
    nextCycle();
    out_ready = 1'b0;
    checkOutput("bp_second_released", 64'(out_valid), 64'd0);

    // Reset while the high half is being computed.
    in_valid = 1'b1;
    input1   = 32'hFFFF_FFFF;
    input2   = 32'h0000_0001;
    nextCycle();
    in_valid = 1'b0;
    nextCycle();
    reset_n = 1'b0;
    nextCycle();
    reset_n = 1'b1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out", 64'(out), 64'd0);
    checkOutput("midrst_carry_out", 64'(carry_out), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("midrst_no_pulse", 64'(out_valid), 64'd0);
    end
    applyStimulus("after_rst", 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
